// File: rtl/pdi_pkg.sv
// Shared PDI pipeline definitions: frame geometry defaults, capture FSM encoding
// and the RGB565 -> RGB888 expansion also used by the display stage.
package pdi_pkg;

  localparam int PDI_IMG_W        = 320;
  localparam int PDI_IMG_H        = 240;
  localparam int PDI_ADDR_W       = 17;
  localparam int PDI_FRAME_PIXELS = PDI_IMG_W * PDI_IMG_H;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cam_state_t;

  // Bit replication fills the low bits so full-scale 5/6-bit values map to 255.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-stage synchronizer for a 1-bit camera strobe with rise/fall detection
// on the synchronized level.
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cam_capture.sv
// Captures one RGB565 frame from an oversampled OV7670-style port into frame BRAM.
// Build option CAM_TEST_PATTERN_EN replaces camera pixel data with 8 colour bars.
module cam_capture
  import pdi_pkg::*;
#(
  parameter int IMG_W       = PDI_IMG_W,
  parameter int IMG_H       = PDI_IMG_H,
  parameter int ADDR_W      = PDI_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  output logic              done,
  output logic              short_frame,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              we,
  output logic [ADDR_W-1:0] addr_write,
  output logic [7:0]        red_data_out,
  output logic [7:0]        green_data_out,
  output logic [7:0]        blue_data_out,
  output cam_state_t        state_dbg
);

  localparam int FRAME_N = IMG_W * IMG_H;
  localparam int XW      = $clog2(IMG_W + 1);
  localparam int YW      = $clog2(IMG_H + 1);
  localparam int CW      = $clog2(FRAME_N + 1);

  localparam logic [XW-1:0]     IMG_W_X   = XW'(IMG_W);
  localparam logic [YW-1:0]     IMG_H_Y   = YW'(IMG_H);
  localparam logic [YW-1:0]     LAST_Y    = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [CW-1:0]     FRAME_CNT = CW'(FRAME_N);

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic vsync_lvl, vsync_rise, vsync_fall;
  logic href_lvl, href_rise, href_fall;
  logic [7:0] data_sync_q [SYNC_STAGES];
  logic [7:0] data_lvl;

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk(clk), .rst(rst), .d_i(cam_pclk),
    .level_o(pclk_lvl), .rise_o(pclk_rise), .fall_o(pclk_fall)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk(clk), .rst(rst), .d_i(cam_vsync),
    .level_o(vsync_lvl), .rise_o(vsync_rise), .fall_o(vsync_fall)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
    .clk(clk), .rst(rst), .d_i(cam_href),
    .level_o(href_lvl), .rise_o(href_rise), .fall_o(href_fall)
  );

  // Data runs through the same depth as href so both line up with the pclk edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      data_sync_q[0] <= cam_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end
  assign data_lvl = data_sync_q[SYNC_STAGES-1];

  logic unused_sync;
  assign unused_sync = &{1'b0, pclk_lvl, pclk_fall, vsync_lvl, href_rise};

  cam_state_t        state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic              done_q, done_d;
  logic              short_q, short_d;
  logic [23:0]       pix_rgb;

`ifdef CAM_TEST_PATTERN_EN
  localparam int            BAR_W = (IMG_W >= 8) ? IMG_W / 8 : 1;
  localparam logic [XW-1:0] BAR_X = XW'(BAR_W);
  logic [XW-1:0] bar_idx;
  logic [2:0]    bar;
  logic          unused_pat;

  always_comb begin
    bar_idx = x_q / BAR_X;
    bar     = (bar_idx > XW'(7)) ? 3'd7 : bar_idx[2:0];
    pix_rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
  end
  assign unused_pat = &{1'b0, byte0_q};
`else
  assign pix_rgb = rgb565_to_rgb888({byte0_q, data_lvl});
`endif

  // active is a level request; done answers it and is held until active drops.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    byte0_d = byte0_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    done_d  = done_q;
    short_d = short_q;

    case (state_q)
      ST_IDLE: begin
        if (active && !done_q) state_d = ST_ARM;
        else if (done_q && !active) done_d = 1'b0;
      end
      ST_ARM: begin
        if (vsync_fall) begin
          state_d = ST_CAPTURE;
          phase_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          cnt_d   = '0;
          addr_d  = '0;
        end
      end
      ST_CAPTURE: begin
        if (href_fall) begin
          x_d     = '0;
          phase_d = 1'b0;
          if (x_q != '0 && y_q < IMG_H_Y) begin
            y_d = y_q + 1'b1;
            if (y_q < LAST_Y) base_d = base_q + IMG_W_A;
          end
        end else if (pclk_rise && href_lvl) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            byte0_d = data_lvl;
          end else begin
            if (x_q < IMG_W_X && y_q < IMG_H_Y) begin
              we_d   = 1'b1;
              addr_d = base_q + ADDR_W'(x_q);
              r_d    = pix_rgb[23:16];
              g_d    = pix_rgb[15:8];
              b_d    = pix_rgb[7:0];
              cnt_d  = cnt_q + 1'b1;
            end
            if (x_q < IMG_W_X) x_d = x_q + 1'b1;
          end
        end
        // A final pixel landing with vsync rise still counts as a full frame.
        if (cnt_d == FRAME_CNT || vsync_rise) begin
          state_d = ST_DONE;
          short_d = (cnt_d != FRAME_CNT);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      byte0_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      byte0_q <= byte0_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      done_q  <= done_d;
      short_q <= short_d;
    end
  end

  assign done           = done_q;
  assign short_frame    = short_q;
  assign we             = we_q;
  assign addr_write     = addr_q;
  assign red_data_out   = r_q;
  assign green_data_out = g_q;
  assign blue_data_out  = b_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture: camera BFM at clk/4, frame-level reference
// model feeding an expected-write queue, per-cycle write comparison.
module tb_cam_capture;
  import pdi_pkg::*;

`ifdef CAM_TEST_PATTERN_EN
  localparam int W = 16;
`else
  localparam int W = 4;
`endif
  localparam int H     = 2;
  localparam int AW    = 6;
  localparam int FRAME = W * H;
  localparam int EW    = AW + 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          active = 1'b0;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b1;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          done, short_frame, we;
  logic [AW-1:0] addr_write;
  logic [7:0]    red_data_out, green_data_out, blue_data_out;
  cam_state_t    state_dbg;

  cam_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .active(active), .done(done), .short_frame(short_frame),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .we(we), .addr_write(addr_write), .red_data_out(red_data_out),
    .green_data_out(green_data_out), .blue_data_out(blue_data_out), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model state
  bit m_on = 0, m_arm = 0, m_end = 0, m_short = 0;
  int m_x = 0, m_y = 0, m_n = 0;

  function automatic logic [23:0] model_pix(input int x, input logic [7:0] b0, input logic [7:0] b1);
`ifdef CAM_TEST_PATTERN_EN
    int k;
    k = x / (W / 8);
    if (k > 7) k = 7;
    return {((k & 4) != 0) ? 8'hFF : 8'h00, ((k & 2) != 0) ? 8'hFF : 8'h00,
            ((k & 1) != 0) ? 8'hFF : 8'h00};
`else
    int r5, g6, b5;
    r5 = x * 0 + (int'(b0) >> 3);
    g6 = ((int'(b0) & 7) << 3) | (int'(b1) >> 5);
    b5 = int'(b1) & 31;
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
`endif
  endfunction

  task automatic model_pixel(input logic [7:0] b0, input logic [7:0] b1);
    if (!m_on) return;
    if (m_x < W && m_y < H) begin
      exp_q.push_back({AW'(m_y * W + m_x), model_pix(m_x, b0, b1)});
      m_n++;
      if (m_n == FRAME) begin
        m_on = 0;
        m_end = 1;
        m_short = 0;
      end
    end
    m_x++;
  endtask

  // write comparison, every cycle
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (we) begin
        check("we_single_cycle", {63'd0, we_prev}, 64'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write actual addr=%0d required none", addr_write);
        end else begin
          check("write", {addr_write, red_data_out, green_data_out, blue_data_out},
                exp_q.pop_front());
        end
      end
      we_prev = we;
    end else begin
      we_prev = 1'b0;
    end
  end

  // driver tasks
  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    cam_href = 1'b1;
    cam_pclk = 1'b0;
    clk_n(2);
    cam_pclk = 1'b1;
    clk_n(2);
  endtask

  task automatic end_line();
    cam_pclk = 1'b0;
    clk_n(1);
    cam_href = 1'b0;
    clk_n(2);
    cam_pclk = 1'b1;
    clk_n(2);
    cam_pclk = 1'b0;
    clk_n(2);
  endtask

  task automatic send_line(input int npix, input bit odd, input bit red);
    logic [7:0] b0, b1;
    for (int p = 0; p < npix; p++) begin
      b0 = red ? 8'hF8 : 8'($urandom_range(0, 255));
      b1 = red ? 8'h00 : 8'($urandom_range(0, 255));
      send_byte(b0);
      model_pixel(b0, b1);
      send_byte(b1);
    end
    if (odd) send_byte(8'($urandom_range(0, 255)));
    if (m_on && m_x > 0) m_y++;
    m_x = 0;
    end_line();
  endtask

  task automatic vs_rise();
    cam_pclk = 1'b0;
    cam_vsync = 1'b1;
    if (m_on) begin
      m_on = 0;
      m_end = 1;
      m_short = (m_n < FRAME);
    end
    clk_n(8);
  endtask

  task automatic vs_fall();
    cam_vsync = 1'b0;
    if (m_arm) begin
      m_arm = 0;
      m_on = 1;
      m_x = 0;
      m_y = 0;
      m_n = 0;
    end
    clk_n(8);
  endtask

  task automatic arm();
    active = 1'b1;
    m_arm = 1;
    clk_n(2);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) clk_n(1);
    check("done_rise", {63'd0, done}, 64'd1);
  endtask

  task automatic finish_frame();
    clk_n(6);
    check("drain", 64'(exp_q.size()), 64'd0);
    wait_done();
    check("short_frame", {63'd0, short_frame}, {63'd0, m_short});
    active = 1'b0;
    clk_n(1);
    check("done_clear", {63'd0, done}, 64'd0);
    m_end = 0;
  endtask

  initial begin
    rst = 1'b0;
    clk_n(4);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_short", {63'd0, short_frame}, 64'd0);
    check("rst_addr", 64'(addr_write), 64'd0);
    check("rst_rgb", {40'd0, red_data_out, green_data_out, blue_data_out}, 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst = 1'b1;
    clk_n(2);

    // full frame of pure red
    arm();
    vs_fall();
    for (int l = 0; l < H; l++) send_line(W, 0, 1);
    vs_rise();
    check("s1_done", {63'd0, done}, 64'd1);
    check("s1_last_addr", 64'(addr_write), 64'(FRAME - 1));
`ifdef CAM_TEST_PATTERN_EN
    check("s1_last_rgb", {40'd0, red_data_out, green_data_out, blue_data_out}, 64'hFFFFFF);
`else
    check("s1_last_rgb", {40'd0, red_data_out, green_data_out, blue_data_out}, 64'hFF0000);
`endif
    finish_frame();

    // active raised mid-frame: nothing until the next vsync fall
    vs_fall();
    send_line(2, 0, 0);
    arm();
    send_line(W, 0, 0);
    check("arm_wait_state", 64'(state_dbg), 64'(ST_ARM));
    vs_rise();
    vs_fall();
    for (int l = 0; l < H; l++) send_line(W, 0, 0);
    vs_rise();
    finish_frame();

    // byte-only line, odd-byte line, over-long line
    arm();
    vs_fall();
    send_line(0, 1, 0);
    send_line(1, 1, 0);
    send_line(W + 1, 0, 0);
    vs_rise();
    finish_frame();

    // vsync rises after W+1 pixels
    arm();
    vs_fall();
    send_line(W, 0, 0);
    send_line(1, 0, 0);
    vs_rise();
    check("short_addr_max", 64'(addr_write), 64'(W));
    finish_frame();
    check("short_lit", {63'd0, short_frame}, 64'd1);

    // reset during capture
    arm();
    vs_fall();
    send_line(W, 0, 0);
    check("pre_rst_state", 64'(state_dbg), 64'(ST_CAPTURE));
    rst = 1'b0;
    clk_n(1);
    check("mid_rst_we", {63'd0, we}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_addr", 64'(addr_write), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst = 1'b1;
    m_on = 0;
    m_arm = 1;
    check("mid_rst_drain", 64'(exp_q.size()), 64'd0);
    clk_n(2);
    send_line(2, 0, 0);
    vs_rise();
    vs_fall();
    for (int l = 0; l < H; l++) send_line(W, 0, 0);
    vs_rise();
    finish_frame();

    // random frames
    for (int f = 0; f < 6; f++) begin
      int nl;
      arm();
      vs_fall();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) send_line($urandom_range(0, W + 1), 1'($urandom_range(0, 1)), 0);
      vs_rise();
      finish_frame();
    end

    clk_n(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
